// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and helpers for the mem_access stage
package riscv_mem_pkg;

    localparam int DMEM_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'd0,
        MEM_HALF   = 2'd1,
        MEM_WORD   = 2'd2,
        MEM_DOUBLE = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_t;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_offset_mask(mem_size_t size);
        case (size)
            MEM_HALF:   return 3'b001;
            MEM_WORD:   return 3'b011;
            MEM_DOUBLE: return 3'b111;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - shift, truncate and sign/zero-extend a load doubleword
module load_extract
    import riscv_mem_pkg::*;
(
    input  logic [DMEM_DATA_WIDTH-1:0] rdata,
    input  logic [2:0]                 offset,
    input  logic [1:0]                 size,
    input  logic                       is_unsigned,
    output logic [DMEM_DATA_WIDTH-1:0] data
);

    logic [DMEM_DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (mem_size_t'(size))
            MEM_BYTE: data = is_unsigned ? {56'd0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
            MEM_HALF: data = is_unsigned ? {48'd0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
            MEM_WORD: data = is_unsigned ? {32'd0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store memory-access stage; optional MEM_MISALIGN_CHECK_EN
module mem_access
    import riscv_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH          = 64,
    parameter int REGISTER_WIDTH         = 64,
    parameter int REGISTERNO_WIDTH       = 5,
    parameter int INSTRUCTION_NAME_WIDTH = 96
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_enable,
    output logic                              out_ready,
    input  logic [REGISTER_WIDTH-1:0]         in_alu_result,
    input  logic [REGISTER_WIDTH-1:0]         in_rs2_value,
    input  logic [ADDRESS_WIDTH-1:0]          in_phy_addr,
    input  logic [REGISTERNO_WIDTH-1:0]       in_rd_regno,
    input  logic                              in_mm_load_bool,
    input  logic                              in_mm_store_bool,
    input  logic                              in_update_rd_bool,
    input  logic                              in_branch_taken_bool,
    input  logic [1:0]                        in_mem_size,
    input  logic                              in_mem_unsigned,
    input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
    input  logic                              in_flush,
    output logic                              out_dmem_req,
    output logic [ADDRESS_WIDTH-1:0]          out_dmem_addr,
    input  logic                              in_dmem_gnt,
    input  logic                              in_dmem_rvalid,
    input  logic [DMEM_DATA_WIDTH-1:0]        in_dmem_rdata,
    output logic                              out_enable,
    output logic [REGISTER_WIDTH-1:0]         out_alu_result,
    output logic [REGISTER_WIDTH-1:0]         out_mdata,
    output logic [REGISTER_WIDTH-1:0]         out_rs2_value,
    output logic [ADDRESS_WIDTH-1:0]          out_phy_addr,
    output logic [REGISTERNO_WIDTH-1:0]       out_rd_regno,
    output logic                              out_mm_load_bool,
    output logic                              out_update_rd_bool,
    output logic                              out_branch_taken_bool,
    output logic [INSTRUCTION_NAME_WIDTH-1:0] out_opcode_name,
    output logic                              out_misalign
);

    mem_state_t                 state;
    mem_size_t                  lat_size;
    logic                       lat_unsigned;
    logic                       misaligned;
    logic [2:0]                 ext_offset;
    logic [DMEM_DATA_WIDTH-1:0] ext_data;

`ifdef MEM_MISALIGN_CHECK_EN
    logic [2:0] in_mask;
    assign in_mask    = size_offset_mask(mem_size_t'(in_mem_size));
    assign misaligned = (in_mm_load_bool || in_mm_store_bool) && (|(in_phy_addr[2:0] & in_mask));
`else
    logic unused_store_bool;
    assign unused_store_bool = in_mm_store_bool;
    assign misaligned        = 1'b0;
`endif

    // Offset bits below the access size are dropped so extraction stays in-lane.
    assign ext_offset = out_phy_addr[2:0] & ~size_offset_mask(lat_size);
    assign out_ready  = (state == ST_IDLE);

    load_extract u_load_extract (
        .rdata       (in_dmem_rdata),
        .offset      (ext_offset),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .data        (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= ST_IDLE;
            lat_size              <= MEM_BYTE;
            lat_unsigned          <= 1'b0;
            out_dmem_req          <= 1'b0;
            out_dmem_addr         <= '0;
            out_enable            <= 1'b0;
            out_alu_result        <= '0;
            out_mdata             <= '0;
            out_rs2_value         <= '0;
            out_phy_addr          <= '0;
            out_rd_regno          <= '0;
            out_mm_load_bool      <= 1'b0;
            out_update_rd_bool    <= 1'b0;
            out_branch_taken_bool <= 1'b0;
            out_opcode_name       <= '0;
            out_misalign          <= 1'b0;
        end else begin
            out_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_enable && !in_flush) begin
                        out_alu_result        <= in_alu_result;
                        out_rs2_value         <= in_rs2_value;
                        out_phy_addr          <= in_phy_addr;
                        out_rd_regno          <= in_rd_regno;
                        out_mm_load_bool      <= in_mm_load_bool;
                        out_update_rd_bool    <= in_update_rd_bool && !misaligned;
                        out_branch_taken_bool <= in_branch_taken_bool;
                        out_opcode_name       <= in_opcode_name;
                        out_misalign          <= misaligned;
                        out_mdata             <= '0;
                        lat_size              <= mem_size_t'(in_mem_size);
                        lat_unsigned          <= in_mem_unsigned;
                        if (in_mm_load_bool && !misaligned) begin
                            out_dmem_req  <= 1'b1;
                            out_dmem_addr <= {in_phy_addr[ADDRESS_WIDTH-1:3], 3'b000};
                            state         <= ST_REQ;
                        end else begin
                            out_enable <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (in_dmem_gnt) begin
                        out_dmem_req <= 1'b0;
                        if (in_dmem_rvalid) begin
                            state <= ST_IDLE;
                            if (!in_flush) begin
                                out_mdata  <= REGISTER_WIDTH'(ext_data);
                                out_enable <= 1'b1;
                            end
                        end else begin
                            state <= in_flush ? ST_DRAIN : ST_WAIT;
                        end
                    end else if (in_flush) begin
                        out_dmem_req <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (in_dmem_rvalid) begin
                        state <= ST_IDLE;
                        if (!in_flush) begin
                            out_mdata  <= REGISTER_WIDTH'(ext_data);
                            out_enable <= 1'b1;
                        end
                    end else if (in_flush) begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    // The cache still owes one response for the killed load.
                    if (in_dmem_rvalid) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with a byte-level load model
module tb_mem_access;

    typedef struct {
        logic        load;
        logic        store;
        logic        upd;
        logic        br;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [63:0] addr;
        logic [4:0]  rd;
        logic [95:0] name;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_enable;
    logic        out_ready;
    logic [63:0] in_alu_result, in_rs2_value, in_phy_addr;
    logic [4:0]  in_rd_regno;
    logic        in_mm_load_bool, in_mm_store_bool, in_update_rd_bool, in_branch_taken_bool;
    logic [1:0]  in_mem_size;
    logic        in_mem_unsigned;
    logic [95:0] in_opcode_name;
    logic        in_flush;
    logic        out_dmem_req;
    logic [63:0] out_dmem_addr;
    logic        in_dmem_gnt, in_dmem_rvalid;
    logic [63:0] in_dmem_rdata;
    logic        out_enable;
    logic [63:0] out_alu_result, out_mdata, out_rs2_value, out_phy_addr;
    logic [4:0]  out_rd_regno;
    logic        out_mm_load_bool, out_update_rd_bool, out_branch_taken_bool;
    logic [95:0] out_opcode_name;
    logic        out_misalign;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_enable             (in_enable),
        .out_ready             (out_ready),
        .in_alu_result         (in_alu_result),
        .in_rs2_value          (in_rs2_value),
        .in_phy_addr           (in_phy_addr),
        .in_rd_regno           (in_rd_regno),
        .in_mm_load_bool       (in_mm_load_bool),
        .in_mm_store_bool      (in_mm_store_bool),
        .in_update_rd_bool     (in_update_rd_bool),
        .in_branch_taken_bool  (in_branch_taken_bool),
        .in_mem_size           (in_mem_size),
        .in_mem_unsigned       (in_mem_unsigned),
        .in_opcode_name        (in_opcode_name),
        .in_flush              (in_flush),
        .out_dmem_req          (out_dmem_req),
        .out_dmem_addr         (out_dmem_addr),
        .in_dmem_gnt           (in_dmem_gnt),
        .in_dmem_rvalid        (in_dmem_rvalid),
        .in_dmem_rdata         (in_dmem_rdata),
        .out_enable            (out_enable),
        .out_alu_result        (out_alu_result),
        .out_mdata             (out_mdata),
        .out_rs2_value         (out_rs2_value),
        .out_phy_addr          (out_phy_addr),
        .out_rd_regno          (out_rd_regno),
        .out_mm_load_bool      (out_mm_load_bool),
        .out_update_rd_bool    (out_update_rd_bool),
        .out_branch_taken_bool (out_branch_taken_bool),
        .out_opcode_name       (out_opcode_name),
        .out_misalign          (out_misalign)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: pick the naturally aligned n-byte lane, assemble it byte by byte, extend.
    function automatic logic [63:0] model_load(logic [63:0] addr, logic [1:0] size,
                                               logic uns, logic [63:0] rdata);
        int n;
        int off;
        logic [63:0] v;
        n   = 1 << size;
        off = (int'(addr[2:0]) / n) * n;
        v   = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = rdata[8*(off+j) +: 8];
        if (!uns && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
        return v;
    endfunction

    function automatic logic model_misaligned(instr_t t);
`ifdef MEM_MISALIGN_CHECK_EN
        return (t.load || t.store) && ((int'(t.addr[2:0]) % (1 << t.size)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic instr_t mk(logic load, logic store, logic [1:0] size, logic uns,
                                  logic [63:0] alu, logic [63:0] rs2, logic [63:0] addr,
                                  logic [4:0] rd);
        instr_t t;
        t.load = load;  t.store = store;  t.upd = !store;  t.br = 1'b0;
        t.size = size;  t.uns = uns;      t.alu = alu;     t.rs2 = rs2;
        t.addr = addr;  t.rd = rd;        t.name = {$urandom, $urandom, $urandom};
        return t;
    endfunction

    task automatic drive(input instr_t t);
        in_alu_result        = t.alu;
        in_rs2_value         = t.rs2;
        in_phy_addr          = t.addr;
        in_rd_regno          = t.rd;
        in_mm_load_bool      = t.load;
        in_mm_store_bool     = t.store;
        in_update_rd_bool    = t.upd;
        in_branch_taken_bool = t.br;
        in_mem_size          = t.size;
        in_mem_unsigned      = t.uns;
        in_opcode_name       = t.name;
    endtask

    task automatic chk_bundle(input instr_t t, input logic [63:0] md, input logic mis);
        chk("out_enable", out_enable, 1);
        chk("alu_result", out_alu_result, t.alu);
        chk("rs2_value", out_rs2_value, t.rs2);
        chk("phy_addr", out_phy_addr, t.addr);
        chk("rd_regno", out_rd_regno, t.rd);
        chk("mm_load", out_mm_load_bool, t.load);
        chk("update_rd", out_update_rd_bool, t.upd && !mis);
        chk("branch_taken", out_branch_taken_bool, t.br);
        chk("opcode_name", out_opcode_name, t.name);
        chk("mdata", out_mdata, md);
        chk("misalign", out_misalign, mis);
        chk("req_idle", out_dmem_req, 0);
    endtask

    // Runs one instruction; gd = cycles before grant, rd_dly = cycles from grant to response.
    task automatic run_txn(input instr_t t, input int gd, input int rd_dly, input logic [63:0] rdata);
        logic        mis;
        logic [63:0] md;
        mis = model_misaligned(t);
        md  = (t.load && !mis) ? model_load(t.addr, t.size, t.uns, rdata) : 64'd0;
        chk("ready_before", out_ready, 1);
        drive(t);
        in_enable = 1'b1;
        @(negedge clk);
        in_enable = 1'b0;
        if (t.load && !mis) begin
            for (int i = 0; i <= gd; i++) begin
                chk("req_held", out_dmem_req, 1);
                chk("req_addr", out_dmem_addr, {t.addr[63:3], 3'b000});
                chk("busy_req", out_ready, 0);
                chk("no_enable_req", out_enable, 0);
                in_dmem_rdata = {$urandom, $urandom};
                if (i < gd) @(negedge clk);
            end
            in_dmem_gnt = 1'b1;
            if (rd_dly == 0) begin
                in_dmem_rvalid = 1'b1;
                in_dmem_rdata  = rdata;
            end
            @(negedge clk);
            in_dmem_gnt    = 1'b0;
            in_dmem_rvalid = 1'b0;
            if (rd_dly > 0) begin
                for (int i = 1; i < rd_dly; i++) begin
                    chk("no_enable_wait", out_enable, 0);
                    chk("busy_wait", out_ready, 0);
                    @(negedge clk);
                end
                in_dmem_rvalid = 1'b1;
                in_dmem_rdata  = rdata;
                @(negedge clk);
                in_dmem_rvalid = 1'b0;
            end
        end
        chk_bundle(t, md, mis);
        @(negedge clk);
        chk("enable_pulse", out_enable, 0);
    endtask

    initial begin
        instr_t t;
        logic [63:0] rd_word;
        reset = 1'b1;  in_enable = 1'b0;  in_flush = 1'b0;
        in_dmem_gnt = 1'b0;  in_dmem_rvalid = 1'b0;  in_dmem_rdata = '0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk("rst_enable", out_enable, 0);
        chk("rst_req", out_dmem_req, 0);
        chk("rst_misalign", out_misalign, 0);
        chk("rst_update_rd", out_update_rd_bool, 0);
        chk("rst_mm_load", out_mm_load_bool, 0);
        chk("rst_branch", out_branch_taken_bool, 0);
        chk("rst_mdata", out_mdata, 0);
        chk("rst_alu", out_alu_result, 0);
        chk("rst_ready", out_ready, 1);
        reset = 1'b0;

        // add, then lb / lbu on the byte holding 0x80
        run_txn(mk(0, 0, 0, 0, 64'h1234, 0, 0, 5), 0, 0, 0);
        run_txn(mk(1, 0, 0, 0, 0, 0, 64'h1003, 7), 0, 1, 64'h0000_0000_8000_0000);
        chk("lb_const", out_mdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_txn(mk(1, 0, 0, 1, 0, 0, 64'h1003, 7), 0, 0, 64'h0000_0000_8000_0000);
        chk("lbu_const", out_mdata, 64'h80);
        // lw with delayed grant and response
        run_txn(mk(1, 0, 2, 0, 0, 0, 64'h1004, 9), 3, 2, 64'h9876_5432_0000_1111);
        chk("lw_const", out_mdata, 64'hFFFF_FFFF_9876_5432);
        // sd never touches the cache
        run_txn(mk(0, 1, 3, 0, 0, 64'hDEAD, 64'h2000, 0), 0, 0, 0);
        // unaligned halfword: misalign flag or cleared offset
        run_txn(mk(1, 0, 1, 0, 0, 0, 64'h1001, 3), 1, 1, 64'h0123_4567_89AB_CDEF);

        // flush in WAIT: response discarded, then normal operation
        t = mk(1, 0, 3, 0, 0, 0, 64'h3000, 4);
        drive(t);  in_enable = 1'b1;
        @(negedge clk);  in_enable = 1'b0;  in_dmem_gnt = 1'b1;
        @(negedge clk);  in_dmem_gnt = 1'b0;  in_flush = 1'b1;
        @(negedge clk);  in_flush = 1'b0;
        chk("drain_busy", out_ready, 0);
        chk("drain_no_enable", out_enable, 0);
        in_dmem_rvalid = 1'b1;  in_dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);  in_dmem_rvalid = 1'b0;
        chk("drain_discard", out_enable, 0);
        chk("drain_ready", out_ready, 1);
        run_txn(mk(0, 0, 0, 0, 64'h55, 0, 0, 1), 0, 0, 0);

        // flush in IDLE with valid input, and flush in REQ without grant
        drive(mk(0, 0, 0, 0, 64'h77, 0, 0, 2));
        in_enable = 1'b1;  in_flush = 1'b1;
        @(negedge clk);  in_enable = 1'b0;  in_flush = 1'b0;
        chk("flush_idle", out_enable, 0);
        drive(mk(1, 0, 2, 0, 0, 0, 64'h4000, 2));  in_enable = 1'b1;
        @(negedge clk);  in_enable = 1'b0;  in_flush = 1'b1;
        @(negedge clk);  in_flush = 1'b0;
        chk("flush_req_ready", out_ready, 1);
        chk("flush_req_noreq", out_dmem_req, 0);
        chk("flush_req_noen", out_enable, 0);

        // reset mid-load: a late response must be ignored
        drive(mk(1, 0, 3, 0, 0, 0, 64'h5000, 6));  in_enable = 1'b1;
        @(negedge clk);  in_enable = 1'b0;  in_dmem_gnt = 1'b1;
        @(negedge clk);  in_dmem_gnt = 1'b0;  reset = 1'b1;
        @(negedge clk);  reset = 1'b0;
        chk("rstmid_ready", out_ready, 1);
        in_dmem_rvalid = 1'b1;
        @(negedge clk);  in_dmem_rvalid = 1'b0;
        chk("rstmid_ignored", out_enable, 0);

        // randomized mix of ALU ops, loads and stores
        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            t = mk(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 31)));
            t.br = 1'($urandom_range(0, 1));
            rd_word = {$urandom, $urandom};
            run_txn(t, $urandom_range(0, 3), $urandom_range(0, 3), rd_word);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
